// File: rtl/param_alu_mc.sv
// Multi-cycle parameterised ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one cycle; MUL is an iterative shift-add over W cycles.
module param_alu_mc #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [W-1:0] y_hi,
  output logic         Z,
  output logic         N,
  output logic         C,
  output logic         V,
  output logic         err
);
  localparam int unsigned LW = $clog2(W);
  localparam int unsigned CW = LW + 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_ROL = 4'h9;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2*W-1:0]  r_acc, w_acc_nxt, r_mcand, w_mcand_nxt, w_acc_step;
  logic [W-1:0]    r_mplier, w_mplier_nxt;
  logic [W-1:0]    r_y, w_y_nxt, r_y_hi, w_y_hi_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic            r_z, r_n, r_c, r_v, r_err;
  logic            w_z_nxt, w_n_nxt, w_c_nxt, w_v_nxt, w_err_nxt;
  logic            w_accept;

  // Single-cycle datapath; wide intermediates expose the carry / last shifted-out bit
  logic [LW-1:0]     w_sh;
  logic [W:0]        w_add, w_sub, w_shl, w_shr;
  logic signed [W:0] w_sra;
  logic [31:0]       w_rol_back;
  logic [W-1:0]      w_rol, w_res_y;
  logic              w_res_c, w_res_v, w_res_err, w_res_z, w_res_n;

  assign w_sh       = b[LW-1:0];
  assign w_add      = {1'b0, a} + {1'b0, b};
  assign w_sub      = {1'b0, a} - {1'b0, b};
  assign w_shl      = {1'b0, a} << w_sh;
  assign w_shr      = {a, 1'b0} >> w_sh;
  assign w_sra      = $signed({a, 1'b0}) >>> w_sh;
  assign w_rol_back = 32'(W) - 32'(w_sh);
  assign w_rol      = (a << w_sh) | (a >> w_rol_back);

  always_comb begin
    w_res_y   = '0;
    w_res_c   = 1'b0;
    w_res_v   = 1'b0;
    w_res_err = 1'b0;
    case (op)
      OP_ADD: begin
        w_res_y = w_add[W-1:0];
        w_res_c = w_add[W];
        w_res_v = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_res_y = w_sub[W-1:0];
        w_res_c = ~w_sub[W];
        w_res_v = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
      end
      OP_AND: w_res_y = a & b;
      OP_OR:  w_res_y = a | b;
      OP_XOR: w_res_y = a ^ b;
      OP_SHL: begin
        w_res_y = w_shl[W-1:0];
        w_res_c = w_shl[W];
      end
      OP_SHR: begin
        w_res_y = w_shr[W:1];
        w_res_c = w_shr[0];
      end
      OP_SRA: begin
        w_res_y = w_sra[W:1];
        w_res_c = w_sra[0];
      end
      OP_ROL: begin
        w_res_y = w_rol;
        w_res_c = (w_sh != '0) && w_rol[0];
      end
      OP_MUL: ;
      default: w_res_err = 1'b1;
    endcase
  end

  assign w_res_z    = (w_res_y == '0);
  assign w_res_n    = w_res_y[W-1];
  assign in_ready   = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept   = in_valid && in_ready;
  assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Next-state and datapath register updates
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_acc_nxt       = r_acc;
    w_mcand_nxt     = r_mcand;
    w_mplier_nxt    = r_mplier;
    w_y_nxt         = r_y;
    w_y_hi_nxt      = r_y_hi;
    w_out_valid_nxt = r_out_valid;
    w_z_nxt         = r_z;
    w_n_nxt         = r_n;
    w_c_nxt         = r_c;
    w_v_nxt         = r_v;
    w_err_nxt       = r_err;
    case (r_state)
      S_IDLE: ;
      S_CALC: begin
        w_acc_nxt    = w_acc_step;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_y_nxt         = w_acc_step[W-1:0];
          w_y_hi_nxt      = w_acc_step[2*W-1:W];
          w_z_nxt         = (w_acc_step == '0);
          w_n_nxt         = w_acc_step[2*W-1];
          w_c_nxt         = (w_acc_step[2*W-1:W] != '0);
          w_v_nxt         = (w_acc_step[2*W-1:W] != '0);
          w_err_nxt       = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new request (from IDLE or a draining DONE) overrides the above
    if (w_accept) begin
      if (op == OP_MUL) begin
        w_state_nxt     = S_CALC;
        w_cnt_nxt       = CW'(W);
        w_acc_nxt       = '0;
        w_mcand_nxt     = {{W{1'b0}}, a};
        w_mplier_nxt    = b;
        w_out_valid_nxt = 1'b0;
      end else begin
        w_state_nxt     = S_DONE;
        w_out_valid_nxt = 1'b1;
        w_y_nxt         = w_res_y;
        w_y_hi_nxt      = '0;
        w_z_nxt         = w_res_z;
        w_n_nxt         = w_res_n;
        w_c_nxt         = w_res_c;
        w_v_nxt         = w_res_v;
        w_err_nxt       = w_res_err;
      end
    end
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_y         <= '0;
      r_y_hi      <= '0;
      r_out_valid <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_y         <= w_y_nxt;
      r_y_hi      <= w_y_hi_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_z         <= w_z_nxt;
      r_n         <= w_n_nxt;
      r_c         <= w_c_nxt;
      r_v         <= w_v_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign Z         = r_z;
  assign N         = r_n;
  assign C         = r_c;
  assign V         = r_v;
  assign err       = r_err;

endmodule

// File: tb/tb_param_alu_mc.sv
// Self-checking bench for param_alu_mc: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_param_alu_mc;
  localparam int unsigned W  = 8;
  localparam int unsigned RW = 2 * W + 5;
  localparam int          M  = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y, y_hi;
  logic         Z, N, C, V, err;

  int n_cmp = 0;
  int n_err = 0;

  param_alu_mc #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .Z(Z), .N(N), .C(C), .V(V), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] outs();
    return {y_hi, y, Z, N, C, V, err};
  endfunction

  // Reference model: {y_hi, y, Z, N, C, V, err} from plain integer arithmetic
  function automatic logic [RW-1:0] model(input logic [3:0] o, input logic [W-1:0] ia,
                                          input logic [W-1:0] ib);
    int av, bv, sa, sb, s, r, hi, lo, sres;
    logic c, v, e, z, n;
    av = int'(ia); bv = int'(ib);
    sa = (av >= M / 2) ? av - M : av;
    sb = (bv >= M / 2) ? bv - M : bv;
    s  = bv % W;
    hi = 0; lo = 0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      4'd0: begin
        lo = (av + bv) % M; c = (av + bv) >= M;
        sres = sa + sb; v = (sres > M / 2 - 1) || (sres < -(M / 2));
      end
      4'd1: begin
        lo = (av - bv + M) % M; c = (av >= bv);
        sres = sa - sb; v = (sres > M / 2 - 1) || (sres < -(M / 2));
      end
      4'd2: lo = av & bv;
      4'd3: lo = av | bv;
      4'd4: lo = av ^ bv;
      4'd5: begin lo = (av << s) % M; c = (s != 0) && (((av >> (W - s)) & 1) == 1); end
      4'd6: begin lo = av >> s;       c = (s != 0) && (((av >> (s - 1)) & 1) == 1); end
      4'd7: begin lo = (sa >>> s) & (M - 1); c = (s != 0) && (((av >> (s - 1)) & 1) == 1); end
      4'd8: begin lo = (av * bv) % M; hi = (av * bv) / M; c = (hi != 0); v = c; end
      4'd9: begin
        r = av;
        for (int k = 0; k < s; k++) r = ((r << 1) | (r >> (W - 1))) % M;
        lo = r; c = (s != 0) && ((r & 1) == 1);
      end
      default: e = 1'b1;
    endcase
    z = (o == 4'd8) ? ((hi == 0) && (lo == 0)) : (lo == 0);
    n = (o == 4'd8) ? (hi >= M / 2) : (lo >= M / 2);
    return {W'(hi), W'(lo), z, n, c, v, e};
  endfunction

  // Issue one op, wait for its result, check latency, CALC in_ready and the result
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [RW-1:0] exp);
    int k;
    int lat_exp;
    lat_exp = (o == 4'd8) ? W + 1 : 1;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = ia; b = ib; out_ready = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); #1; k++; end
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 40) begin
      if (o == 4'd8) check({tag, "_calc_rdy"}, 64'(in_ready), 64'(0));
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat_exp));
    check({tag, "_result"}, 64'(outs()), 64'(exp));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    int           seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", 64'(outs()), 64'(0));
    check("reset_ovalid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    #1 check("post_reset_in_ready", 64'(in_ready), 64'(1));

    // Directed corner cases (expected values written out by hand)
    run_op("add_ovf",  4'd0, 8'h7F, 8'h01, {8'h00, 8'h80, 5'b01010});
    run_op("sub_brw",  4'd1, 8'h00, 8'h01, {8'h00, 8'hFF, 5'b01000});
    run_op("mul_max",  4'd8, 8'hFF, 8'hFF, {8'hFE, 8'h01, 5'b01110});
    run_op("sra_neg",  4'd7, 8'h81, 8'h01, {8'h00, 8'hC0, 5'b01100});
    run_op("illegal",  4'hF, 8'h5A, 8'h33, {8'h00, 8'h00, 5'b10001});
    run_op("mul_zero", 4'd8, 8'h00, 8'h37, {8'h00, 8'h00, 5'b10000});
    run_op("shl_s0",   4'd5, 8'h81, 8'h08, {8'h00, 8'h81, 5'b01000});
    run_op("rol_3",    4'd9, 8'h81, 8'h03, {8'h00, 8'h0C, 5'b00000});

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
    end

    // Three back-to-back ADDs, then a 3-cycle output stall
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 8'd1; b = 8'd2; out_ready = 1'b1;
    @(posedge clk); #1 a = 8'd3; b = 8'd4;
    @(negedge clk);
    check("b2b_1", 64'({out_valid, y}), 64'({1'b1, 8'd3}));
    @(posedge clk); #1 a = 8'd5; b = 8'd6;
    @(negedge clk);
    check("b2b_2", 64'({out_valid, y}), 64'({1'b1, 8'd7}));
    @(posedge clk); #1 out_ready = 1'b0; a = 8'h10; b = 8'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_outs", i), 64'({out_valid, outs()}),
            64'({1'b1, 8'h00, 8'd11, 5'b00000}));
      check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("drain_ovalid", 64'(out_valid), 64'(0));

    // Reset in the 4th CALC cycle of a MUL aborts it
    in_valid = 1'b1; op = 4'd8; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_outs", 64'({out_valid, outs()}), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(1));
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen++; end
    check("abort_no_result", 64'(seen), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
